writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Writeback stage that sits directly upstream of the 32x32 register file and drives its write port (`rd`, `wr`, `Din`). It merges single-cycle ALU results with memory load responses into one registered write per cycle. Load responses are buffered in a small FIFO. A load-pending scoreboard tells the issue logic which destination registers are still waiting on memory.

## Interface
Parameters:
- `LQ_DEPTH`, default 2: load-response FIFO depth; must be a power of two, at least 2.

Ports:
- `CLK`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `alu_valid`, input, 1: ALU result present.
- `alu_rd`, input, 5: ALU destination register.
- `alu_data`, input, 32: ALU result.
- `alu_ready`, output, 1: ALU result accepted this cycle when high together with `alu_valid`.
- `ld_valid`, input, 1: load response present.
- `ld_rd`, input, 5: load destination register.
- `ld_data`, input, 32: load data.
- `ld_ready`, output, 1: FIFO can accept a response (not full).
- `iss_valid`, input, 1: an instruction issues this cycle.
- `iss_is_load`, input, 1: the issuing instruction is a load.
- `iss_rd`, input, 5: destination register of the issuing instruction.
- `rd`, output, 5: register-file write address (registered).
- `wr`, output, 1: register-file write enable (registered).
- `Din`, output, 32: register-file write data (registered).
- `ld_busy`, output, 32: bit i high means register i has an outstanding load.

## Operation
FIFO:
- Push on `ld_valid && ld_ready`.
- Pop when the load path wins arbitration (see below).
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- The FIFO has no bypass: a response is always stored before it can be written back.
- Read and write pointers wrap modulo `LQ_DEPTH`.
- The count is `clog2(LQ_DEPTH)+1` bits wide and always stays in 0..`LQ_DEPTH`.

Arbitration, evaluated each cycle before the clock edge:
- If the FIFO is full, the load head wins and `alu_ready` is 0. This prevents starvation.
- Otherwise, if `alu_valid` is high, the ALU wins. `alu_ready` is 1 whenever the FIFO is not full.
- Otherwise, if the FIFO is not empty, the load head wins.
- Otherwise there is no write.

Output register, updated at the edge:
- `rd` and `Din` take the winner's destination and data.
- `wr` takes 1 if there is a winner and the winner's destination is not 0; otherwise 0.
- A winner with destination 0 is consumed but discarded: it pops or is accepted, and `wr` is 0.
- When there is no winner, `wr` is 0 and `rd`/`Din` hold their previous values.

Scoreboard `ld_busy`:
- Set bit `iss_rd` on `iss_valid && iss_is_load && iss_rd != 0`.
- Clear bit `r` when a load entry with destination `r` wins arbitration.
- If a set and a clear hit the same register in the same cycle, the set wins: the new load is outstanding.
- Bit 0 is always 0.
- ALU writebacks never touch `ld_busy`.

## Timing
- Reset (asynchronous, while `reset` is 0): `rd`=0, `wr`=0, `Din`=0, FIFO empty (pointers and count 0), `ld_busy`=0, `alu_ready`=1, `ld_ready`=1.
- Reset asserted mid-operation discards all buffered loads and pending bits immediately. No write is issued on the first edge after release.
- ALU latency: accepted at edge N, so `wr`/`rd`/`Din` are valid during cycle N+1 and the register file captures them at edge N+1.
- Load latency with an idle ALU: pushed at edge N, pops at edge N+1, `wr` is valid during cycle N+2. The `ld_busy` bit clears at edge N+1.
- `alu_ready` and `ld_ready` are combinational from the FIFO count only, with no path from the `*_valid` inputs.
- Throughput: one register-file write per cycle maximum.
- Full FIFO with a concurrent `ld_valid`: `ld_ready`=0, so there is no push. The head still pops that cycle, and `ld_ready` returns to 1 the next cycle.

## Test plan
- Reset check: hold `reset`=0 with random inputs → all outputs at their reset values. Release, then send `alu_valid`, `alu_rd`=5, `alu_data`=0xDEADBEEF → the next cycle shows `wr`=1, `rd`=5, `Din`=0xDEADBEEF.
- Load path: issue a load to r7 → `ld_busy[7]`=1. Send response `ld_rd`=7, `ld_data`=0x12345678 with the ALU idle → `wr` two cycles after the push with `Din`=0x12345678, and `ld_busy[7]`=0 one cycle after the push.
- Starvation guard: hold `alu_valid` continuously and push 2 loads (`LQ_DEPTH`=2) → `alu_ready`=0 and `ld_ready`=0 for exactly one cycle, then load 1 is written. With `alu_valid` still held, load 2 is written only once the FIFO is full again.
- r0 handling: ALU to r0, a load to r0, and an issue of a load to r0 → `wr`=0 for all three, `ld_busy`=0, and the FIFO still drains.
- Set/clear collision: the load to r3 pops in the same cycle that a new load to r3 issues → the old data is written and `ld_busy[3]` stays 1.
- Mid-operation reset: two loads buffered and `ld_busy`=0x000000C0, then pulse `reset` low → FIFO empty, `ld_busy`=0, and `wr` stays 0 after release.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback stage feeding the register-file write port: merges ALU results with
// FIFO-buffered load responses into one registered write per cycle, plus a load-pending scoreboard.
module writeback_arbiter #(
    parameter int LQ_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        iss_valid,
    input  logic        iss_is_load,
    input  logic [4:0]  iss_rd,
    output logic [4:0]  rd,
    output logic        wr,
    output logic [31:0] Din,
    output logic [31:0] ld_busy
);

    localparam int AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(LQ_DEPTH);

    logic [4:0]    lq_rd_q   [LQ_DEPTH];
    logic [31:0]   lq_data_q [LQ_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full, empty, push, pop, alu_win, any_win;
    logic [4:0]    head_rd, win_rd;
    logic [31:0]   head_data, win_data;
    logic [4:0]    rd_q;
    logic          wr_q;
    logic [31:0]   din_q;
    logic [31:0]   busy_q, busy_d;

    // Arbitration: a full queue forces the load head through so loads cannot starve.
    always_comb begin
        full      = (cnt_q == FULL_CNT);
        empty     = (cnt_q == '0);
        push      = ld_valid && !full;
        pop       = full || (!alu_valid && !empty);
        alu_win   = !full && alu_valid;
        any_win   = pop || alu_win;
        head_rd   = lq_rd_q[rptr_q];
        head_data = lq_data_q[rptr_q];
        win_rd    = pop ? head_rd : alu_rd;
        win_data  = pop ? head_data : alu_data;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Clear is applied before set so a same-cycle reissue to the popping register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (iss_valid && iss_is_load && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            lq_rd_q[wptr_q]   <= ld_rd;
            lq_data_q[wptr_q] <= ld_data;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            busy_q <= '0;
            rd_q   <= '0;
            wr_q   <= 1'b0;
            din_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            wr_q   <= any_win && (win_rd != 5'd0);
            if (any_win) begin
                rd_q  <= win_rd;
                din_q <= win_data;
            end
        end
    end

    assign alu_ready = !full;
    assign ld_ready  = !full;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign Din       = din_q;
    assign ld_busy   = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: inputs change and outputs are checked on the falling edge.
module tb_writeback_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        iss_valid;
    logic        iss_is_load;
    logic [4:0]  iss_rd;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] Din;
    logic [31:0] ld_busy;

    int total = 0;
    int bad   = 0;

    writeback_arbiter #(.LQ_DEPTH(2)) dut (
        .CLK(CLK), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .iss_valid(iss_valid), .iss_is_load(iss_is_load), .iss_rd(iss_rd),
        .rd(rd), .wr(wr), .Din(Din), .ld_busy(ld_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        iss_valid = 0; iss_is_load = 0; iss_rd = 0;
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic [4:0] r, input logic [31:0] d);
        chk({tag, ".wr"}, 32'(wr), 32'(w));
        chk({tag, ".rd"}, 32'(rd), 32'(r));
        chk({tag, ".Din"}, Din, d);
    endtask

    initial begin
        reset = 0;
        idle();
        // Reset held with random traffic
        for (int i = 0; i < 4; i++) begin
            tick();
            alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
            ld_valid = 1'($urandom); ld_rd = 5'($urandom); ld_data = $urandom;
            iss_valid = 1; iss_is_load = 1; iss_rd = 5'($urandom_range(1, 31));
        end
        tick();
        chk_wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.busy", ld_busy, 32'h0);
        chk("rst.alu_ready", 32'(alu_ready), 32'h1);
        chk("rst.ld_ready", 32'(ld_ready), 32'h1);
        idle();
        reset = 1;
        tick();
        chk("post_rst.wr", 32'(wr), 32'h0);

        // ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        chk_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        idle();
        tick();
        chk_wr("alu_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // Load path
        iss_valid = 1; iss_is_load = 1; iss_rd = 7;
        tick();
        chk("ld.busy_set", ld_busy, 32'h80);
        idle();
        ld_valid = 1; ld_rd = 7; ld_data = 32'h12345678;
        tick();
        chk("ld.push_wr", 32'(wr), 32'h0);
        chk("ld.push_busy", ld_busy, 32'h80);
        idle();
        tick();
        chk_wr("ld.wb", 1'b1, 5'd7, 32'h12345678);
        chk("ld.busy_clr", ld_busy, 32'h0);
        tick();
        chk("ld.after_wr", 32'(wr), 32'h0);

        // Starvation guard with ALU held busy
        alu_valid = 1; alu_rd = 1; alu_data = 32'h100;
        ld_valid = 1; ld_rd = 10; ld_data = 32'hAAAA0001;
        tick();
        chk_wr("sg.alu0", 1'b1, 5'd1, 32'h100);
        chk("sg.alu_ready1", 32'(alu_ready), 32'h1);
        alu_data = 32'h101; ld_rd = 11; ld_data = 32'hBBBB0002;
        tick();
        chk_wr("sg.alu1", 1'b1, 5'd1, 32'h101);
        chk("sg.full_alu_ready", 32'(alu_ready), 32'h0);
        chk("sg.full_ld_ready", 32'(ld_ready), 32'h0);
        alu_data = 32'h102; ld_rd = 13; ld_data = 32'hDDDD0004;
        tick();
        chk_wr("sg.load1", 1'b1, 5'd10, 32'hAAAA0001);
        chk("sg.alu_ready_back", 32'(alu_ready), 32'h1);
        chk("sg.ld_ready_back", 32'(ld_ready), 32'h1);
        ld_valid = 0; alu_data = 32'h103;
        tick();
        chk_wr("sg.alu3", 1'b1, 5'd1, 32'h103);
        alu_data = 32'h104; ld_valid = 1; ld_rd = 12; ld_data = 32'hCCCC0003;
        tick();
        chk_wr("sg.alu4", 1'b1, 5'd1, 32'h104);
        chk("sg.full2", 32'(alu_ready), 32'h0);
        ld_valid = 0; alu_data = 32'h105;
        tick();
        chk_wr("sg.load2", 1'b1, 5'd11, 32'hBBBB0002);
        alu_valid = 0;
        tick();
        chk_wr("sg.load3", 1'b1, 5'd12, 32'hCCCC0003);
        tick();
        chk("sg.drained_wr", 32'(wr), 32'h0);
        chk("sg.drained_ready", 32'(ld_ready), 32'h1);

        // r0 handling
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        tick();
        chk("r0.alu_wr", 32'(wr), 32'h0);
        idle();
        ld_valid = 1; ld_rd = 0; ld_data = 32'h66;
        iss_valid = 1; iss_is_load = 1; iss_rd = 0;
        tick();
        chk("r0.iss_busy", ld_busy, 32'h0);
        chk("r0.push_wr", 32'(wr), 32'h0);
        idle();
        tick();
        chk("r0.pop_wr", 32'(wr), 32'h0);
        chk("r0.pop_din", Din, 32'h66);
        ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
        tick();
        idle();
        tick();
        chk_wr("r0.drain", 1'b1, 5'd9, 32'h99);

        // Set/clear collision on r3
        iss_valid = 1; iss_is_load = 1; iss_rd = 3;
        tick();
        idle();
        ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
        tick();
        idle();
        iss_valid = 1; iss_is_load = 1; iss_rd = 3;
        tick();
        chk_wr("col.wb", 1'b1, 5'd3, 32'h33);
        chk("col.busy", ld_busy, 32'h8);
        idle();
        ld_valid = 1; ld_rd = 3; ld_data = 32'h34;
        tick();
        idle();
        tick();
        chk_wr("col.wb2", 1'b1, 5'd3, 32'h34);
        chk("col.busy_clr", ld_busy, 32'h0);

        // Mid-operation reset
        iss_valid = 1; iss_is_load = 1; iss_rd = 6;
        tick();
        iss_rd = 7;
        tick();
        idle();
        chk("mr.busy", ld_busy, 32'hC0);
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        ld_valid = 1; ld_rd = 6; ld_data = 32'h66;
        tick();
        ld_rd = 7; ld_data = 32'h77;
        tick();
        chk("mr.full", 32'(alu_ready), 32'h0);
        idle();
        reset = 0;
        #1;
        chk("mr.busy_rst", ld_busy, 32'h0);
        chk("mr.wr_rst", 32'(wr), 32'h0);
        chk("mr.ready_rst", 32'(ld_ready), 32'h1);
        chk("mr.alu_ready_rst", 32'(alu_ready), 32'h1);
        tick();
        reset = 1;
        tick();
        chk("mr.wr_rel1", 32'(wr), 32'h0);
        tick();
        chk("mr.wr_rel2", 32'(wr), 32'h0);
        chk("mr.busy_rel", ld_busy, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
